// File: rtl/pll_settle_sequencer.sv
// Per-channel PLL lock qualifier and timing-engine reset sequencer.
// Each channel filters raw lock, enforces a lock timeout budget and releases tArstFs one cycle after settling.
module pll_settle_sequencer #(
  parameter int BIT_WIDTH      = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 8
) (
  input  logic                 ck,
  input  logic                 arst,
  input  logic [BIT_WIDTH-1:0] pllEnable,
  input  logic [BIT_WIDTH-1:0] pllLock,
  input  logic                 clrErr,
  input  logic                 isolateM1,
  output logic [BIT_WIDTH-1:0] pllSettled,
  output logic [BIT_WIDTH-1:0] tArstFs,
  output logic [BIT_WIDTH-1:0] settleTimeout
);

  localparam logic [CNT_W-1:0] SET_C = SETTLE_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] TMO_C = TIMEOUT_CYCLES[CNT_W-1:0];

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT,
    ST_SETTLE,
    ST_SETTLED,
    ST_FAIL
  } state_t;

  for (genvar g = 0; g < BIT_WIDTH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] scnt_q, scnt_d, tcnt_q, tcnt_d;
    logic [CNT_W-1:0] scnt_inc, tcnt_inc;
    logic             settled_q, settled_d;
    logic             tarst_q, tarst_d;
    logic             err_q, err_d;
    logic             tmo_set;

    always_ff @(posedge ck) begin
      if (arst) begin
        state_q   <= ST_OFF;
        scnt_q    <= '0;
        tcnt_q    <= '0;
        settled_q <= 1'b0;
        tarst_q   <= 1'b1;
        err_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        scnt_q    <= scnt_d;
        tcnt_q    <= tcnt_d;
        settled_q <= settled_d;
        tarst_q   <= tarst_d;
        err_q     <= err_d;
      end
    end

    always_comb begin
      scnt_inc = (scnt_q == '1) ? scnt_q : scnt_q + 1'b1;
      tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
      state_d  = state_q;
      scnt_d   = scnt_q;
      tcnt_d   = tcnt_q;
      tmo_set  = 1'b0;
      if (!pllEnable[g]) begin
        state_d = ST_OFF;
        scnt_d  = '0;
        tcnt_d  = '0;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            state_d = ST_WAIT;
            scnt_d  = '0;
            tcnt_d  = '0;
          end
          ST_WAIT, ST_SETTLE: begin
            tcnt_d = tcnt_inc;
            if (pllLock[g]) begin
              // First lock sample in WAIT counts as 1; a completed settle outranks the timeout.
              scnt_d  = (state_q == ST_WAIT) ? CNT_W'(1) : scnt_inc;
              state_d = (scnt_d >= SET_C) ? ST_SETTLED : ST_SETTLE;
            end else begin
              scnt_d  = '0;
              state_d = ST_WAIT;
            end
            if (state_d != ST_SETTLED && tcnt_inc >= TMO_C) begin
              state_d = ST_FAIL;
              tmo_set = 1'b1;
            end
          end
          ST_SETTLED: begin
            if (!pllLock[g]) begin
              state_d = ST_WAIT;
              scnt_d  = '0;
              tcnt_d  = '0;
            end
          end
          ST_FAIL: state_d = ST_FAIL;
          default: begin
            state_d = ST_OFF;
            scnt_d  = '0;
            tcnt_d  = '0;
          end
        endcase
      end
    end

    always_comb begin
      settled_d = (state_d == ST_SETTLED);
      tarst_d   = !((state_q == ST_SETTLED) && (state_d == ST_SETTLED));
      err_d     = tmo_set | (err_q & ~clrErr);
    end

    assign pllSettled[g]    = settled_q & ~isolateM1;
    assign tArstFs[g]       = tarst_q | isolateM1;
    assign settleTimeout[g] = err_q;
  end

endmodule

// File: tb/tb_pll_settle_sequencer.sv
// Directed scoreboard bench for pll_settle_sequencer with SETTLE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_pll_settle_sequencer;

  logic       ck = 1'b0;
  logic       arst;
  logic [1:0] pllEnable, pllLock;
  logic       clrErr, isolateM1;
  logic [1:0] pllSettled, tArstFs, settleTimeout;

  always #5 ck = ~ck;

  pll_settle_sequencer #(
    .BIT_WIDTH(2),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(20),
    .CNT_W(8)
  ) dut (
    .ck(ck),
    .arst(arst),
    .pllEnable(pllEnable),
    .pllLock(pllLock),
    .clrErr(clrErr),
    .isolateM1(isolateM1),
    .pllSettled(pllSettled),
    .tArstFs(tArstFs),
    .settleTimeout(settleTimeout)
  );

  typedef struct {
    string      tag;
    logic [1:0] es;
    logic [1:0] et;
    logic [1:0] ee;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    n_assert++;
    assert (pllSettled === e.es) else begin
      n_fail++;
      $error("FAIL %s.pllSettled: observed %b expected %b", e.tag, pllSettled, e.es);
    end
    n_assert++;
    assert (tArstFs === e.et) else begin
      n_fail++;
      $error("FAIL %s.tArstFs: observed %b expected %b", e.tag, tArstFs, e.et);
    end
    n_assert++;
    assert (settleTimeout === e.ee) else begin
      n_fail++;
      $error("FAIL %s.settleTimeout: observed %b expected %b", e.tag, settleTimeout, e.ee);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then compare.
  task automatic step(input string tag, input logic r, input logic [1:0] en, input logic [1:0] lk,
                      input logic clr, input logic iso,
                      input logic [1:0] es, input logic [1:0] et, input logic [1:0] ee);
    exp_t e;
    arst      = r;
    pllEnable = en;
    pllLock   = lk;
    clrErr    = clr;
    isolateM1 = iso;
    e.tag = tag;
    e.es  = es;
    e.et  = et;
    e.ee  = ee;
    sb.push_back(e);
    @(posedge ck);
    #1;
    check_one();
  endtask

  initial begin
    // Reset, then basic lock: enable at edge 1, lock from edge 3, settled at 6, tArstFs low at 7
    step("reset",     1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("en_e1",     1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("wait_e2",   1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("lock_e3",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("lock_e4",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("lock_e5",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("settle_e6", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00);
    step("release_e7",1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);
    step("hold_e8",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);

    // Lock loss drops settled and reasserts tArstFs on the same edge
    step("lock_loss", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);

    // Glitch: 3 high, 1 low, 4 high -> single rise on the 4th high
    for (int k = 0; k < 3; k++)
      step("glitch_hi1", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("glitch_lo",  1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++)
      step("glitch_hi2", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("glitch_set", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00);
    step("glitch_rel", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);

    // Timeout: enable at E, no lock, error at E+20; later locks ignored; clrErr clears
    step("tmo_off",   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("tmo_en",    1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 19; k++)
      step("tmo_wait", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("tmo_hit",   1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01);
    for (int k = 0; k < 6; k++)
      step("fail_lock_ign", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01);
    step("clr_err",   1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 2'b11, 2'b00);
    step("drop_en",   1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("reen",      1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++)
      step("reen_lock", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("reen_set",  1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00);
    step("reen_rel",  1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);

    // Settle completes on the timeout edge: settled wins, no error
    step("tie_off",   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("tie_en",    1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 16; k++)
      step("tie_wait", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++)
      step("tie_lock", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("tie_edge",  1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00);
    step("tie_rel",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);

    // clrErr on the same edge as a new timeout: set wins
    step("cset_off",  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("cset_en",   1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 19; k++)
      step("cset_wait", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("cset_hit",  1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b11, 2'b01);
    step("cset_hold", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01);
    step("cset_clr",  1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b11, 2'b00);

    // Isolation on a settled ch0 while ch1 runs toward its own timeout
    step("iso_off",   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("iso_en",    1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++)
      step("iso_lock", 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("iso_set",   1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00);
    step("iso_rel0",  1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);
    for (int k = 0; k < 5; k++)
      step("iso_clamp", 1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 2'b00, 2'b11, 2'b00);
    step("iso_release", 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);
    for (int k = 0; k < 8; k++)
      step("ch1_wait", 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);
    step("ch1_tmo",   1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10);
    step("iso_no_err_clamp", 1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 2'b00, 2'b11, 2'b10);

    // Reset while SETTLED clears everything, then a full settle is needed
    step("rst_settled", 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("rst_rel",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++)
      step("rst_relock", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("rst_set",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00);
    step("rst_rel2",  1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);

    // Reset mid-SETTLE
    step("mid_loss",  1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 2; k++)
      step("mid_lock", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("mid_rst",   1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("mid_rel",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++)
      step("mid_relock", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
    step("mid_set",   1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00);
    step("mid_rel2",  1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
